interrupt_ack_sequencer: RTL
============================

# interrupt_ack_sequencer

Control sequencer that sits between the 8259A priority resolver and the CPU bus interface. It raises INT when the resolver reports a serviceable request and runs the two-pulse 8086-mode INTA handshake. It owns the In-Service Register (set on acknowledge, cleared by EOI or auto-EOI) and feeds the highest in-service level back to the resolver. It also drives the interrupt vector onto the data bus during the second INTA pulse.

## Interface
- No parameters; width fixed at 8 interrupt levels.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- resolved_request  in  8  one-hot (or zero) winning request from priority resolver
- inta_n  in  1  CPU interrupt acknowledge, active low, already synchronous to clk
- vector_base  in  5  ICW2 bits T7..T3
- auto_eoi  in  1  ICW4 AEOI enable
- eoi_valid  in  1  single-cycle OCW2 EOI command strobe
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific (qualified by eoi_valid)
- eoi_level  in  3  level for specific EOI
- int_out  out  1  interrupt request to CPU
- in_service_register  out  8  ISR
- highest_level_in_service  out  8  one-hot lowest-index set ISR bit; 8'h00 when ISR empty
- clear_request  out  8  one-cycle one-hot pulse clearing the acknowledged IRR bit
- data_out  out  8  vector byte
- data_out_en  out  1  data bus drive enable

## Operation
- Reset values: state IDLE; int_out 0; ISR 8'h00; clear_request 8'h00; data_out 8'h00; data_out_en 0; captured level 0; inta_n history register 1.
- Edge detection: register inta_n each cycle.
  - Fall = prev 1 and current 0.
  - Rise = prev 0 and current 1.
- States:
  - IDLE: resolved_request != 0 -> PENDING, int_out=1.
  - PENDING: int_out held 1, including if resolved_request drops to zero.
    - INTA fall -> ACK1, int_out=0.
    - Capture level = index of the set bit in resolved_request.
    - If resolved_request = 0 at the fall (spurious): level = 7, ISR and clear_request untouched.
    - Otherwise ISR[level] set and clear_request[level] pulsed for one cycle.
  - ACK1: INTA rise -> WAIT2. data_out_en stays 0.
  - WAIT2: INTA fall -> ACK2, data_out={vector_base, level}, data_out_en=1.
  - ACK2: INTA rise -> IDLE, data_out_en=0. If auto_eoi and not spurious, ISR[level] cleared in the same cycle.
- Falls outside PENDING/WAIT2 and rises outside ACK1/ACK2 are ignored.
- EOI, accepted in any state:
  - Non-specific clears the lowest-index set ISR bit; no effect if ISR is empty.
  - Specific clears ISR[eoi_level].
- ISR update: ISR_next = (ISR & ~clear_mask) | set_mask, where clear_mask = EOI clear OR AEOI clear.
  - A set from INTA wins over a clear on the same bit in the same cycle.
- Non-specific EOI selection uses the pre-update ISR.
- highest_level_in_service is combinational from the registered ISR.
- Reset asserted mid-handshake forces every output and register to its reset value immediately. After release, the block waits in IDLE and does not resume the old handshake.

## Timing
- int_out asserts 1 cycle after resolved_request becomes nonzero in IDLE.
- ISR set, clear_request pulse and int_out deassert: 1 cycle after the cycle in which the INTA fall is sampled.
- data_out/data_out_en valid 1 cycle after the second fall is sampled; deasserted 1 cycle after the rise is sampled.
- AEOI clear lands on that same rise-following edge.
- After ACK2->IDLE, a pending request raises int_out no earlier than 1 cycle after IDLE is entered (earliest: 2 cycles after the rise is sampled).
- EOI effect on ISR is visible 1 cycle after eoi_valid.

## Structure
- Shared pic_pkg holds:
  - state encoding localparams (IDLE, PENDING, ACK1, WAIT2, ACK2);
  - a one-hot-to-index function;
  - a lowest-set-bit isolation function (shared with the priority resolver).
- One natural sub-module, isr_register: ISR storage with set/clear masks and the highest_level_in_service output. Everything else stays in the sequencer.

## Test plan
- Normal ack, single request:
  - Stimulus: vector_base=5'b01000, resolved_request=8'b00010000, two INTA pulses.
  - Required: int_out rises; after the first fall ISR=8'h10 and clear_request=8'h10 for one cycle; during the second pulse data_out=8'h44 and data_out_en=1; ISR stays 8'h10 with auto_eoi=0.
- AEOI:
  - Stimulus: same as above with auto_eoi=1.
  - Required: ISR returns to 8'h00 one cycle after the second rise.
- Non-specific EOI:
  - Stimulus: ISR=8'b10000101 (built via three acks), then an eoi_valid pulse.
  - Required: ISR=8'b10000100; highest_level_in_service goes from 8'h01 to 8'h04.
  - Stimulus: a specific EOI with eoi_level=7.
  - Required: ISR=8'b00000100.
- Spurious:
  - Stimulus: resolved_request drops to 0 before the first INTA.
  - Required: ISR unchanged; clear_request 0; vector = {vector_base,3'd7}, e.g. 8'h47.
- Simultaneous events:
  - Stimulus: specific EOI for level 3 in the same cycle the first fall sets level 3.
  - Required: ISR[3]=1 (set wins).
- Reset mid-handshake:
  - Stimulus: assert reset during WAIT2.
  - Required: all outputs 0 immediately; the next INTA pulse is ignored until int_out is raised again.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259A-style interrupt controller blocks.
package pic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PENDING,
        ACK1,
        WAIT2,
        ACK2
    } ack_state_e;

    // Index of the set bit in a one-hot vector; 0 when the vector is empty.
    function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (onehot[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Lowest set bit isolated as a one-hot mask (bit 0 is highest priority).
    function automatic logic [7:0] lowest_set(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

endpackage

// File: rtl/isr_register.sv
// In-Service Register storage: clear-then-set update and priority feedback.
module isr_register
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] set_mask_i,
    input  logic [7:0] clear_mask_i,
    output logic [7:0] isr_o,
    output logic [7:0] highest_o
);

    logic [7:0] isr_q;
    logic [7:0] isr_d;

    // Set is applied after clear so an acknowledge wins over an EOI on the same bit.
    always_comb begin
        isr_d = (isr_q & ~clear_mask_i) | set_mask_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            isr_q <= '0;
        end else begin
            isr_q <= isr_d;
        end
    end

    assign isr_o     = isr_q;
    assign highest_o = lowest_set(isr_q);

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8086-mode INT/INTA handshake sequencer with EOI/AEOI handling and vector drive.
module interrupt_ack_sequencer
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] resolved_request,
    input  logic       inta_n,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic [7:0] clear_request,
    output logic [7:0] data_out,
    output logic       data_out_en
);

    ack_state_e state_q, state_d;
    logic       int_out_q, int_out_d;
    logic [7:0] clear_req_q, clear_req_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_en_q, data_en_d;
    logic [2:0] level_q, level_d;
    logic       spurious_q, spurious_d;
    logic       inta_prev_q;

    logic       inta_fall;
    logic       inta_rise;
    logic [7:0] req_lsb;
    logic [7:0] set_mask;
    logic [7:0] aeoi_clear;
    logic [7:0] eoi_clear;
    logic [7:0] isr;

    assign inta_fall = inta_prev_q & ~inta_n;
    assign inta_rise = ~inta_prev_q & inta_n;
    assign req_lsb   = lowest_set(resolved_request);

    always_comb begin
        state_d     = state_q;
        int_out_d   = int_out_q;
        clear_req_d = '0;
        data_out_d  = data_out_q;
        data_en_d   = data_en_q;
        level_d     = level_q;
        spurious_d  = spurious_q;
        set_mask    = '0;
        aeoi_clear  = '0;
        unique case (state_q)
            IDLE: begin
                if (|resolved_request) begin
                    state_d   = PENDING;
                    int_out_d = 1'b1;
                end
            end
            PENDING: begin
                if (inta_fall) begin
                    state_d   = ACK1;
                    int_out_d = 1'b0;
                    if (|resolved_request) begin
                        level_d     = onehot_to_index(req_lsb);
                        spurious_d  = 1'b0;
                        set_mask    = req_lsb;
                        clear_req_d = req_lsb;
                    end else begin
                        level_d    = 3'd7;
                        spurious_d = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_rise) state_d = WAIT2;
            end
            WAIT2: begin
                if (inta_fall) begin
                    state_d    = ACK2;
                    data_out_d = {vector_base, level_q};
                    data_en_d  = 1'b1;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    state_d    = IDLE;
                    data_out_d = '0;
                    data_en_d  = 1'b0;
                    if (auto_eoi && !spurious_q) aeoi_clear = 8'h01 << level_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Non-specific EOI picks from the ISR as it stands before this cycle's update.
    always_comb begin
        eoi_clear = '0;
        if (eoi_valid) begin
            eoi_clear = eoi_specific ? (8'h01 << eoi_level) : lowest_set(isr);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            int_out_q   <= 1'b0;
            clear_req_q <= '0;
            data_out_q  <= '0;
            data_en_q   <= 1'b0;
            level_q     <= '0;
            spurious_q  <= 1'b0;
            inta_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            int_out_q   <= int_out_d;
            clear_req_q <= clear_req_d;
            data_out_q  <= data_out_d;
            data_en_q   <= data_en_d;
            level_q     <= level_d;
            spurious_q  <= spurious_d;
            inta_prev_q <= inta_n;
        end
    end

    isr_register u_isr (
        .clk          (clk),
        .reset        (reset),
        .set_mask_i   (set_mask),
        .clear_mask_i (eoi_clear | aeoi_clear),
        .isr_o        (isr),
        .highest_o    (highest_level_in_service)
    );

    assign in_service_register = isr;
    assign int_out             = int_out_q;
    assign clear_request       = clear_req_q;
    assign data_out            = data_out_q;
    assign data_out_en         = data_en_q;

endmodule
